// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared types and protocol constants for the serial
// program loader.
//   loader_state_e : loader FSM states (length bytes, word bytes, run, error)
//   rx_state_e     : UART receiver states
//   BYTES_PER_WORD : bytes assembled into one instruction word
//   LEN_BYTES      : bytes in the big-endian word-count prefix
package boot_loader_pkg;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        WORD,
        RUN,
        ERR
    } loader_state_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_BYTES      = 2;

endpackage

// File: rtl/boot_loader_uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-FF input synchroniser.
//   clk_i        : system clock
//   rst_ni       : asynchronous active-low reset
//   rx_i         : raw serial input, idles high
//   byte_valid_o : one-cycle pulse, byte_o holds a good byte
//   byte_o       : received byte (LSB first on the line)
//   frame_err_o  : one-cycle pulse, byte dropped because its stop bit was low
module uart_rx
    import boot_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       frame_err_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_e        state_q;
    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             byte_valid_q;
    logic             frame_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            sync_q       <= 2'b11;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], rx_i};
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                // A low line in idle is a start edge: idle is only re-entered
                // with the line high (stop sample or WAIT_HIGH).
                IDLE: begin
                    if (!sync_q[1]) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        state_q <= sync_q[1] ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {sync_q[1], shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= '0;
                        if (sync_q[1]) begin
                            byte_valid_q <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (sync_q[1]) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_o       = shift_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/boot_loader.sv
// boot_loader: loads a length-prefixed program from a UART line into
// instruction memory and holds the CPU in reset until loading completes.
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   rx         : UART serial input
//   imem_we    : one-cycle instruction-memory write strobe
//   imem_addr  : word-aligned byte address of the word being written
//   imem_wdata : word being written
//   cpu_reset  : active-high CPU reset, released once loading completes
//   done       : program loaded, CPU released
//   frame_err  : sticky, a byte with a bad stop bit was seen
//   len_err    : sticky, requested word count exceeds memory depth
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned ADDR_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        frame_err,
    output logic        len_err
);

    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_ferr;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i       (clk),
        .rst_ni      (reset),
        .rx_i        (rx),
        .byte_valid_o(rx_valid),
        .byte_o      (rx_byte),
        .frame_err_o (rx_ferr)
    );

    loader_state_e state_q;
    logic [7:0]    len_hi_q;
    logic [15:0]   n_q;
    logic [ADDR_W:0] idx_q;
    logic [1:0]    bcnt_q;
    logic [23:0]   asm_q;
    logic          imem_we_q;
    logic [31:0]   imem_addr_q;
    logic [31:0]   imem_wdata_q;
    logic          cpu_reset_q;
    logic          done_q;
    logic          frame_err_q;
    logic          len_err_q;

    logic [15:0] len_full;
    assign len_full = {len_hi_q, rx_byte};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= LEN_HI;
            len_hi_q     <= '0;
            n_q          <= '0;
            idx_q        <= '0;
            bcnt_q       <= '0;
            asm_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            if (rx_ferr && state_q != RUN) begin
                frame_err_q <= 1'b1;
            end
            case (state_q)
                LEN_HI: begin
                    if (rx_valid) begin
                        len_hi_q <= rx_byte;
                        state_q  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (rx_valid) begin
                        n_q <= len_full;
                        if (len_full == 16'd0) begin
                            // Empty program: release the CPU right away.
                            state_q     <= RUN;
                            cpu_reset_q <= 1'b0;
                            done_q      <= 1'b1;
                        end else if ({1'b0, len_full} > DEPTH) begin
                            state_q   <= ERR;
                            len_err_q <= 1'b1;
                        end else begin
                            state_q <= WORD;
                            idx_q   <= '0;
                            bcnt_q  <= '0;
                        end
                    end
                end
                WORD: begin
                    if (rx_valid) begin
                        if (bcnt_q == 2'(BYTES_PER_WORD - 1)) begin
                            imem_we_q    <= 1'b1;
                            imem_wdata_q <= {asm_q, rx_byte};
                            imem_addr_q  <= 32'({idx_q[ADDR_W-1:0], 2'b00});
                            idx_q        <= idx_q + 1'b1;
                            bcnt_q       <= '0;
                            // done follows one cycle after the final strobe,
                            // so it is raised from RUN rather than here.
                            if (16'(idx_q) + 16'd1 == n_q) begin
                                state_q <= RUN;
                            end
                        end else begin
                            asm_q  <= {asm_q[15:0], rx_byte};
                            bcnt_q <= bcnt_q + 2'd1;
                        end
                    end
                end
                RUN: begin
                    cpu_reset_q <= 1'b0;
                    done_q      <= 1'b1;
                end
                ERR: begin
                    cpu_reset_q <= 1'b1;
                end
                default: state_q <= LEN_HI;
            endcase
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign frame_err  = frame_err_q;
    assign len_err    = len_err_q;

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: drives UART frames into boot_loader and checks every
// output on every cycle against a protocol-level model of the loader.
module tb_boot_loader;

    localparam int CPB = 8;
    localparam int AW  = 4;
    // Cycles from the clock edge before the first low start-bit sample to
    // the negedge where the resulting imem_we is visible:
    // sync (2) + half bit + 9 bits to mid stop, +1 register, +1 sample offset.
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        frame_err;
    logic        len_err;

    boot_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .frame_err (frame_err),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         expq[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    // Protocol model state
    int          m_cnt;
    int          m_hi;
    int          m_n;
    bit          m_stop;
    logic [31:0] m_word;
    int          done_cyc;
    int          lerr_cyc;
    int          ferr_cyc;

    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;
    bit          exp_we;
    bit          exp_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_clear();
        expq.delete();
        m_cnt    = 0;
        m_hi     = 0;
        m_n      = 0;
        m_stop   = 1'b0;
        m_word   = '0;
        done_cyc = -1;
        lerr_cyc = -1;
        ferr_cyc = -1;
    endfunction

    // Byte k of the stream (0-based, good bytes only): 0,1 length; from 2 on,
    // byte k lands in word (k-2)/4 at lane (k-2)%4, lane 0 being the MSB.
    function automatic void model_byte(input logic [7:0] b, input int s);
        int k;
        int pos;
        int w;
        if (m_stop) return;
        k = m_cnt;
        m_cnt++;
        if (k == 0) begin
            m_hi = int'(b);
        end else if (k == 1) begin
            m_n = m_hi * 256 + int'(b);
            if (m_n == 0) begin
                done_cyc = s + LAT;
                m_stop   = 1'b1;
            end else if (m_n > (1 << AW)) begin
                lerr_cyc = s + LAT;
                m_stop   = 1'b1;
            end
        end else begin
            pos = (k - 2) % 4;
            w   = (k - 2) / 4;
            if (pos == 0) m_word = '0;
            m_word = m_word | (32'(b) << (8 * (3 - pos)));
            if (pos == 3) begin
                expq.push_back('{s + LAT, 32'(w * 4), m_word});
                if (w == m_n - 1) begin
                    done_cyc = s + LAT + 1;
                    m_stop   = 1'b1;
                end
            end
        end
    endfunction

    function automatic void model_ferr(input int s);
        if (!m_stop && ferr_cyc < 0) ferr_cyc = s + LAT;
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("rst_imem_we", {31'd0, imem_we}, 32'd0);
            check("rst_imem_addr", imem_addr, 32'd0);
            check("rst_imem_wdata", imem_wdata, 32'd0);
            check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
            check("rst_done", {31'd0, done}, 32'd0);
            check("rst_frame_err", {31'd0, frame_err}, 32'd0);
            check("rst_len_err", {31'd0, len_err}, 32'd0);
            last_addr = '0;
            last_data = '0;
        end else begin
            exp_we = (expq.size() > 0) && (expq[0].cyc == cyc);
            check("imem_we", {31'd0, imem_we}, {31'd0, exp_we});
            if (exp_we) begin
                last_addr = expq[0].addr;
                last_data = expq[0].data;
                void'(expq.pop_front());
            end
            if (imem_we === 1'b1) begin
                log_addr.push_back(imem_addr);
                log_data.push_back(imem_wdata);
            end
            check("imem_addr", imem_addr, last_addr);
            check("imem_wdata", imem_wdata, last_data);
            exp_done = (done_cyc >= 0) && (cyc >= done_cyc);
            check("done", {31'd0, done}, {31'd0, exp_done});
            check("cpu_reset", {31'd0, cpu_reset}, {31'd0, !exp_done});
            check("len_err", {31'd0, len_err}, {31'd0, (lerr_cyc >= 0 && cyc >= lerr_cyc)});
            check("frame_err", {31'd0, frame_err}, {31'd0, (ferr_cyc >= 0 && cyc >= ferr_cyc)});
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the next posedge is the first to sample the start bit.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
        int s;
        s  = cyc;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (stop_ok) model_byte(b, s);
        else model_ferr(s);
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        rx    = 1'b1;
        model_clear();
        log_addr.delete();
        log_data.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic finish_scenario(input string name);
        idle(30);
        check({name, "_pending"}, expq.size(), 32'd0);
    endtask

    initial begin
        int n;
        logic [7:0] b;
        model_clear();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Two-word program, bytes back to back.
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'hAC); send_byte(8'h08); send_byte(8'h00); send_byte(8'h04);
        finish_scenario("two_words");
        check("two_words_count", log_data.size(), 32'd2);
        if (log_data.size() == 2) begin
            check("two_words_addr0", log_addr[0], 32'h0);
            check("two_words_data0", log_data[0], 32'h20080005);
            check("two_words_addr1", log_addr[1], 32'h4);
            check("two_words_data1", log_data[1], 32'hAC080004);
        end
        check("two_words_done", {31'd0, done}, 32'd1);
        check("two_words_cpu_reset", {31'd0, cpu_reset}, 32'd0);

        // Empty program, later bytes ignored.
        do_reset();
        send_byte(8'h00); send_byte(8'h00);
        idle(5);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        finish_scenario("empty");
        check("empty_count", log_data.size(), 32'd0);
        check("empty_done", {31'd0, done}, 32'd1);

        // Oversized length.
        do_reset();
        send_byte(8'h00); send_byte(8'h11);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        finish_scenario("len_err");
        check("len_err_flag", {31'd0, len_err}, 32'd1);
        check("len_err_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("len_err_count", log_data.size(), 32'd0);

        // Frame error mid-stream drops one byte only.
        do_reset();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h55, 1'b0);
        idle(CPB);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        finish_scenario("frame_err");
        check("frame_err_flag", {31'd0, frame_err}, 32'd1);
        check("frame_err_count", log_data.size(), 32'd1);
        if (log_data.size() == 1) begin
            check("frame_err_addr", log_addr[0], 32'h0);
            check("frame_err_data", log_data[0], 32'h11223344);
        end
        check("frame_err_done", {31'd0, done}, 32'd1);

        // Reset mid-word discards the partial word.
        do_reset();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        do_reset();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        finish_scenario("mid_reset");
        check("mid_reset_count", log_data.size(), 32'd1);
        if (log_data.size() == 1) begin
            check("mid_reset_addr", log_addr[0], 32'h0);
            check("mid_reset_data", log_data[0], 32'hDEADBEEF);
        end

        // Short low glitch on idle line is rejected.
        do_reset();
        rx = 1'b0;
        repeat (2) @(negedge clk);
        idle(40);
        check("glitch_frame_err", {31'd0, frame_err}, 32'd0);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hF0); send_byte(8'h0D);
        finish_scenario("glitch");
        check("glitch_count", log_data.size(), 32'd1);
        if (log_data.size() == 1) begin
            check("glitch_data", log_data[0], 32'hCAFEF00D);
        end

        // Random programs with random inter-byte gaps (0 = back to back).
        for (int it = 0; it < 6; it++) begin
            do_reset();
            n = (it == 0) ? (1 << AW) : int'($urandom_range(1, 10));
            send_byte(8'(n >> 8));
            idle(int'($urandom_range(0, 3)));
            send_byte(8'(n));
            for (int j = 0; j < 4 * n; j++) begin
                idle(int'($urandom_range(0, 3)));
                b = 8'($urandom);
                send_byte(b);
            end
            finish_scenario("random");
            check("random_count", log_data.size(), 32'(n));
            check("random_done", {31'd0, done}, 32'd1);
        end

        // Random oversized lengths.
        for (int it = 0; it < 2; it++) begin
            do_reset();
            n = int'($urandom_range((1 << AW) + 1, 4000));
            send_byte(8'(n >> 8));
            send_byte(8'(n));
            send_byte(8'($urandom));
            finish_scenario("random_len_err");
            check("random_len_err_flag", {31'd0, len_err}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
